miner_nonce_dispatcher: RTL and testbench

Job-side initiator for the miner core CCU handshake. It accepts a mining job (header tail, target, nonce range) and builds the padded second 512-bit header chunk for each nonce. It pulses hash_enable, waits for finished, then compares the returned digest against the target. It reports the winning nonce or range exhaustion, and sits between the host/job interface and miner_core_CCU/miner_core_msa.

---
 rtl/miner_nonce_dispatcher_if.sv | 35 +++
 rtl/miner_nonce_dispatcher.sv | 127 ++++++++++++
 tb/tb_miner_nonce_dispatcher.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_nonce_dispatcher_if.sv
// Job-side and core-side signal bundle for the nonce dispatcher.
// The master modport is the dispatcher's view; slave is the host plus hash core.
interface miner_nonce_dispatcher_if #(
   parameter int NONCE_W = 32
);
   // Job handshake: a job moves on a clock edge where job_valid && job_ready.
   // job_ready depends only on dispatcher state, never on job_valid.
   logic               job_valid;
   logic               job_ready;
   logic [95:0]        header_tail;
   logic [255:0]       target;
   logic [NONCE_W-1:0] start_nonce;
   logic [NONCE_W-1:0] end_nonce;
   logic               abort;
   logic               hash_enable;
   logic [511:0]       chunk;
   logic               finished;
   logic [255:0]       digest;
   logic               found;
   logic [NONCE_W-1:0] found_nonce;
   logic               exhausted;
   logic [31:0]        hash_count;

   modport master (
      input  job_valid, header_tail, target, start_nonce, end_nonce, abort,
      input  finished, digest,
      output job_ready, hash_enable, chunk, found, found_nonce, exhausted, hash_count
   );

   modport slave (
      output job_valid, header_tail, target, start_nonce, end_nonce, abort,
      output finished, digest,
      input  job_ready, hash_enable, chunk, found, found_nonce, exhausted, hash_count
   );
endinterface

// File: rtl/miner_nonce_dispatcher.sv
// Walks a nonce range: builds the second header chunk, launches the hash core,
// compares each digest to the target and reports a hit or range exhaustion.
module miner_nonce_dispatcher #(
   parameter int NONCE_W = 32,
   parameter int MSG_LEN = 640
) (
   input  logic                     clk,
   input  logic                     n_rst,
   miner_nonce_dispatcher_if.master bus,
   output logic [2:0]               state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_CHECK  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   localparam logic [63:0] LEN_FIELD = 64'(MSG_LEN);

   state_t             state, state_n;
   logic [95:0]        tail_q;
   logic [255:0]       target_q;
   logic [NONCE_W-1:0] nonce_q, end_q, nonce_inc;
   logic               hit_q;
   logic [511:0]       chunk_q;
   logic [NONCE_W-1:0] found_nonce_q;
   logic [31:0]        hash_count_q;

   logic load_job, capture, advance, found_c, exhausted_c;

   function automatic logic [511:0] build_chunk(input logic [95:0] tail,
                                                input logic [NONCE_W-1:0] nonce);
      return {tail, nonce, 32'h8000_0000, 288'b0, LEN_FIELD};
   endfunction

   assign nonce_inc = nonce_q + 1'b1;

   always_comb begin
      state_n     = state;
      load_job    = 1'b0;
      capture     = 1'b0;
      advance     = 1'b0;
      found_c     = 1'b0;
      exhausted_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.job_valid) begin
               load_job = 1'b1;
               state_n  = S_LAUNCH;
            end
         end
         S_LAUNCH: state_n = bus.abort ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            // A finished coinciding with abort means the core is already idle.
            if (bus.abort) begin
               state_n = bus.finished ? S_IDLE : S_DRAIN;
            end else if (bus.finished) begin
               capture = 1'b1;
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (bus.abort) begin
               state_n = S_IDLE;
            end else if (hit_q) begin
               found_c = 1'b1;
               state_n = S_IDLE;
            end else if (nonce_q == end_q) begin
               exhausted_c = 1'b1;
               state_n     = S_IDLE;
            end else begin
               advance = 1'b1;
               state_n = S_LAUNCH;
            end
         end
         S_DRAIN: if (bus.finished) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= S_IDLE;
         tail_q        <= '0;
         target_q      <= '0;
         nonce_q       <= '0;
         end_q         <= '0;
         hit_q         <= 1'b0;
         chunk_q       <= '0;
         found_nonce_q <= '0;
         hash_count_q  <= '0;
      end else begin
         state <= state_n;
         if (load_job) begin
            tail_q       <= bus.header_tail;
            target_q     <= bus.target;
            nonce_q      <= bus.start_nonce;
            end_q        <= bus.end_nonce;
            hit_q        <= 1'b0;
            hash_count_q <= '0;
            chunk_q      <= build_chunk(bus.header_tail, bus.start_nonce);
         end
         if (capture) begin
            hit_q <= (bus.digest < target_q);
            if (hash_count_q != 32'hFFFF_FFFF) hash_count_q <= hash_count_q + 32'd1;
         end
         if (advance) begin
            nonce_q <= nonce_inc;
            chunk_q <= build_chunk(tail_q, nonce_inc);
         end
         if (found_c) found_nonce_q <= nonce_q;
      end
   end

   assign bus.job_ready   = (state == S_IDLE);
   assign bus.hash_enable = (state == S_LAUNCH);
   assign bus.chunk       = chunk_q;
   assign bus.found       = found_c;
   assign bus.exhausted   = exhausted_c;
   assign bus.found_nonce = found_nonce_q;
   assign bus.hash_count  = hash_count_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Bench for miner_nonce_dispatcher: fixed-latency hash core model, expected
// launch/result queues filled at job issue and drained by a negedge monitor.
module tb_miner_nonce_dispatcher;

   localparam int LAT = 10;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   miner_nonce_dispatcher_if #(.NONCE_W(32)) bus ();

   miner_nonce_dispatcher #(.NONCE_W(32), .MSG_LEN(640)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .bus       (bus.master),
      .state_dbg (state_dbg)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_launch_q[$];
   logic [33:0] exp_evt_q[$];   // {kind, nonce}: kind 01 = found, 10 = exhausted
   logic [95:0] cur_tail;

   logic        hit_en;
   logic [31:0] hit_nonce;
   logic [255:0] hit_dig, miss_dig;

   logic        ready_chk = 1'b0;
   logic        fn_chk = 1'b0;
   logic [31:0] fn_exp;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] dig_for(input logic [31:0] n);
      return (hit_en && n == hit_nonce) ? hit_dig : miss_dig;
   endfunction

   // Hash core model: fixed latency from the hash_enable cycle to finished.
   logic        busy;
   int          cnt;
   logic [31:0] m_nonce;
   initial begin
      bus.finished = 1'b0;
      bus.digest   = '0;
      busy = 1'b0;
      cnt = 0;
      m_nonce = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.finished = 1'b0;
         if (!n_rst) begin
            busy = 1'b0;
         end else begin
            if (busy) begin
               cnt--;
               if (cnt == 0) begin
                  bus.finished = 1'b1;
                  bus.digest   = dig_for(m_nonce);
                  busy = 1'b0;
               end
            end
            if (bus.hash_enable) begin
               busy = 1'b1;
               cnt = LAT;
               m_nonce = bus.chunk[415:384];
            end
         end
      end
   end

   // Monitor: every launch and every result pulse must match the queues.
   initial begin
      logic [31:0] e_n;
      logic [33:0] e_v;
      forever begin
         @(negedge clk);
         if (n_rst) begin
            if (ready_chk) begin
               check("ready_after_result", bus.job_ready, 1'b1);
               ready_chk = 1'b0;
            end
            if (fn_chk) begin
               check("found_nonce", bus.found_nonce, fn_exp);
               fn_chk = 1'b0;
            end
            if (bus.hash_enable) begin
               if (exp_launch_q.size() == 0) check("unexpected_launch", 1'b1, 1'b0);
               else begin
                  e_n = exp_launch_q.pop_front();
                  check("chunk", bus.chunk, {cur_tail, e_n, 32'h8000_0000, 288'b0, 64'd640});
               end
            end
            if (bus.found) begin
               if (exp_evt_q.size() == 0) check("unexpected_found", 1'b1, 1'b0);
               else begin
                  e_v = exp_evt_q.pop_front();
                  check("found_kind", 2'b01, e_v[33:32]);
                  fn_exp = e_v[31:0];
                  fn_chk = 1'b1;
                  ready_chk = 1'b1;
               end
            end
            if (bus.exhausted) begin
               if (exp_evt_q.size() == 0) check("unexpected_exhausted", 1'b1, 1'b0);
               else begin
                  e_v = exp_evt_q.pop_front();
                  check("exhausted_kind", 2'b10, e_v[33:32]);
                  ready_chk = 1'b1;
               end
            end
         end
      end
   end

   task automatic issue_job(input logic [95:0] tail, input logic [255:0] tgt,
                            input logic [31:0] s, input logic [31:0] e);
      @(posedge clk);
      #1;
      cur_tail = tail;
      bus.header_tail = tail;
      bus.target      = tgt;
      bus.start_nonce = s;
      bus.end_nonce   = e;
      bus.job_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.job_valid   = 1'b0;
      bus.header_tail = {$urandom, $urandom, $urandom};
      bus.start_nonce = $urandom;
      bus.end_nonce   = $urandom;
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (bus.job_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic wait_launch(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.hash_enable) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check({tag, "_launch_timeout"}, 1'b0, 1'b1);
   endtask

   // Full job: reference walk of the range, then run and compare.
   task automatic run_job(input string tag, input logic [95:0] tail, input logic [255:0] tgt,
                          input logic [31:0] s, input logic [31:0] e);
      logic [31:0] n = s;
      int attempts = 0;
      for (int i = 0; i < 1000; i++) begin
         exp_launch_q.push_back(n);
         attempts++;
         if (dig_for(n) < tgt) begin
            exp_evt_q.push_back({2'b01, n});
            break;
         end
         if (n == e) begin
            exp_evt_q.push_back({2'b10, 32'h0});
            break;
         end
         n = n + 32'd1;
      end
      issue_job(tail, tgt, s, e);
      wait_idle(tag);
      @(negedge clk);
      #1;
      check({tag, "_hash_count"}, bus.hash_count, 32'(attempts));
      check({tag, "_launch_q_empty"}, 32'(exp_launch_q.size()), 32'd0);
      check({tag, "_evt_q_empty"}, 32'(exp_evt_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_job_ready"}, bus.job_ready, 1'b1);
      check({tag, "_hash_enable"}, bus.hash_enable, 1'b0);
      check({tag, "_found"}, bus.found, 1'b0);
      check({tag, "_exhausted"}, bus.exhausted, 1'b0);
      check({tag, "_found_nonce"}, bus.found_nonce, 32'h0);
      check({tag, "_hash_count"}, bus.hash_count, 32'h0);
      check({tag, "_chunk"}, bus.chunk, 512'h0);
   endtask

   initial begin
      logic [255:0] t_mid;
      bit seen;
      bus.job_valid   = 1'b0;
      bus.abort       = 1'b0;
      bus.header_tail = '0;
      bus.target      = '0;
      bus.start_nonce = '0;
      bus.end_nonce   = '0;
      hit_en = 1'b0;
      hit_nonce = '0;
      hit_dig = '0;
      miss_dig = '0;
      cur_tail = '0;

      #12;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;

      // Immediate hit on the first nonce.
      miss_dig = '0;
      run_job("hit_first", 96'hA5A5_0000_1111_2222_3333_4444, {256{1'b1}}, 32'd5, 32'd7);

      // Never hit: walk 5..7 then exhaust; found_nonce keeps the earlier hit.
      miss_dig = {256{1'b1}};
      run_job("no_hit", 96'h1234_5678_9ABC_DEF0_0F0F_0F0F, 256'h0, 32'd5, 32'd7);
      check("found_nonce_held", bus.found_nonce, 32'd5);

      // Range wraps through all-ones to zero.
      run_job("wrap", {3{32'hCAFE_F00D}}, 256'h0, 32'hFFFF_FFFE, 32'd1);

      // Single hit in the middle of the range.
      t_mid = 256'h1 << 128;
      hit_en = 1'b1;
      hit_nonce = 32'd6;
      hit_dig = '0;
      run_job("hit_mid", 96'hDEAD_BEEF_0000_0001_0000_0002, t_mid, 32'd5, 32'd9);

      // digest == target is a miss; target-1 on the end nonce is a hit only.
      hit_nonce = 32'd12;
      hit_dig = t_mid - 256'd1;
      miss_dig = t_mid;
      run_job("boundary_end_hit", 96'h0BAD_CAFE_1357_9BDF_2468_ACE0, t_mid, 32'd10, 32'd12);
      check("found_nonce_end", bus.found_nonce, 32'd12);

      // Start equals end: exactly one attempt.
      hit_en = 1'b0;
      miss_dig = {256{1'b1}};
      run_job("single", 96'h55, 256'h0, 32'd42, 32'd42);

      // A few random ranges with a random hit position.
      for (int k = 0; k < 3; k++) begin
         logic [31:0] s, e;
         s = $urandom;
         e = s + 32'($urandom_range(0, 4));
         hit_en = 1'b1;
         hit_nonce = s + 32'($urandom_range(0, 6));
         hit_dig = 256'($urandom);
         run_job("random", {$urandom, $urandom, $urandom}, 256'h1 << 64, s, e);
      end
      hit_en = 1'b0;

      // Abort three cycles into WAIT: drain until the core finishes.
      exp_launch_q.push_back(32'd5);
      issue_job(96'h0A0B_0C0D, 256'h0, 32'd5, 32'd7);
      wait_launch("abort");
      repeat (4) @(posedge clk);
      #1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      bus.start_nonce = 32'd100;
      bus.end_nonce   = 32'd100;
      bus.job_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.job_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         check("drain_not_ready", bus.job_ready, 1'b0);
         if (bus.finished) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("drain_finished_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #2;
      check("drain_ready", bus.job_ready, 1'b1);
      check("drain_hash_count", bus.hash_count, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check("drain_launch_q_empty", 32'(exp_launch_q.size()), 32'd0);
      check("drain_no_relaunch", bus.job_ready, 1'b1);

      // A job after the drain runs normally.
      run_job("after_abort", 96'h7777, 256'h0, 32'd20, 32'd21);

      // abort and finished in the same WAIT cycle go straight to IDLE.
      exp_launch_q.push_back(32'd5);
      issue_job(96'h0E0F, 256'h0, 32'd5, 32'd7);
      wait_launch("abort_fin");
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         if (bus.finished) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("abort_fin_timeout", 1'b0, 1'b1);
      bus.abort = 1'b1;
      @(posedge clk);
      #2;
      bus.abort = 1'b0;
      check("abort_fin_ready", bus.job_ready, 1'b1);
      check("abort_fin_hash_count", bus.hash_count, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_fin_evt_q_empty", 32'(exp_evt_q.size()), 32'd0);

      // Chunk layout with nonce 8, then async reset mid-WAIT.
      exp_launch_q.push_back(32'd8);
      issue_job(96'h0123_4567_89AB_CDEF_0123_4567, 256'h0, 32'd8, 32'd8);
      wait_launch("reset_mid");
      repeat (2) @(posedge clk);
      #3;
      n_rst = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_launch_q.delete();
      exp_evt_q.delete();
      ready_chk = 1'b0;
      fn_chk = 1'b0;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      run_job("post_reset", 96'h9, 256'h0, 32'd3, 32'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
